// File: rtl/mips_mc_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mc_ctrl_fsm_pkg
//  Description : Shared encodings for the multicycle MIPS control FSM:
//                state codes, opcodes and datapath select codes.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_mc_ctrl_fsm_pkg;

    // State encodings (4-bit core code; wider state registers zero-extend)
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_I_EXEC    = 4'd10;
    localparam logic [3:0] S_I_WB      = 4'd11;
    localparam logic [3:0] S_JAL       = 4'd12;

    // Supported opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // PCSource codes
    localparam logic [1:0] PCSRC_PC4  = 2'b00;
    localparam logic [1:0] PCSRC_BEQ  = 2'b01;
    localparam logic [1:0] PCSRC_BNE  = 2'b10;
    localparam logic [1:0] PCSRC_JUMP = 2'b11;

    // RegDst codes
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // MemtoReg codes
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // ALUSrcB codes
    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // ALUOp codes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // True for every opcode the FSM knows how to sequence
    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI,
            OP_BEQ, OP_BNE, OP_J, OP_JAL: op_supported = 1'b1;
            default:                      op_supported = 1'b0;
        endcase
    endfunction

endpackage : mips_mc_ctrl_fsm_pkg
`default_nettype wire

// File: rtl/mips_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mc_ctrl_fsm
//  Description : Main control FSM of the multicycle MIPS datapath. Moore
//                decode of all datapath enables; PCWriteEn in BRANCH is
//                qualified combinationally by ZeroFlag.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_mc_ctrl_fsm
    import mips_mc_ctrl_fsm_pkg::*;
#(
    parameter int STATE_W = 4   // must be >= 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    input  logic               ZeroFlag,
    output logic               PCWriteEn,
    output logic [1:0]         PCSource,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [3:0]         w_state4;
    logic [3:0]         w_next4;
    logic               w_hi_nz;

    // Any set bit above the 4-bit core code marks an unused encoding.
    assign w_state4 = state_q[3:0];
    if (STATE_W > 4) begin : g_wide_state
        assign w_hi_nz = |state_q[STATE_W-1:4];
    end else begin : g_narrow_state
        assign w_hi_nz = 1'b0;
    end

    // State register: reset forces FETCH on the next edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_W'(S_FETCH);
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unused codes fall back to FETCH
    always_comb begin
        w_next4 = S_FETCH;
        if (!w_hi_nz) begin
            case (w_state4)
                S_FETCH:     w_next4 = S_DECODE;
                S_DECODE: begin
                    case (Opcode)
                        OP_RTYPE:       w_next4 = S_R_EXEC;
                        OP_LW, OP_SW:   w_next4 = S_MEM_ADDR;
                        OP_ADDI:        w_next4 = S_I_EXEC;
                        OP_BEQ, OP_BNE: w_next4 = S_BRANCH;
                        OP_J:           w_next4 = S_JUMP;
                        OP_JAL:         w_next4 = S_JAL;
                        default:        w_next4 = S_FETCH;
                    endcase
                end
                S_MEM_ADDR:  w_next4 = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  w_next4 = S_MEM_WB;
                S_R_EXEC:    w_next4 = S_R_WB;
                S_I_EXEC:    w_next4 = S_I_WB;
                default:     w_next4 = S_FETCH;
            endcase
        end
        state_d = STATE_W'(w_next4);
    end

    // Output decode from the current state; reset silences every output
    always_comb begin
        PCWriteEn = 1'b0;
        PCSource  = PCSRC_PC4;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = REGDST_RT;
        MemtoReg  = M2R_ALUOUT;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REGB;
        ALUOp     = ALUOP_ADD;
        Illegal   = 1'b0;
        State     = state_q;

        if (reset) begin
            State = '0;
        end else if (!w_hi_nz) begin
            case (w_state4)
                S_FETCH: begin
                    MemRead   = 1'b1;
                    IRWrite   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    PCWriteEn = 1'b1;
                    PCSource  = PCSRC_PC4;
                end
                S_DECODE: begin
                    // Precompute the branch target into ALUOut
                    ALUSrcB = SRCB_IMMSH2;
                    ALUOp   = ALUOP_ADD;
                    Illegal = ~op_supported(Opcode);
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = REGDST_RT;
                    MemtoReg = M2R_MDR;
                end
                S_MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_R_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_R_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = REGDST_RD;
                end
                S_I_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_I_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = REGDST_RT;
                end
                S_BRANCH: begin
                    // Opcode[0] separates bne (1) from beq (0)
                    ALUSrcA   = 1'b1;
                    ALUOp     = ALUOP_SUB;
                    PCSource  = {Opcode[0], ~Opcode[0]};
                    PCWriteEn = ZeroFlag ^ Opcode[0];
                end
                S_JUMP: begin
                    PCWriteEn = 1'b1;
                    PCSource  = PCSRC_JUMP;
                end
                S_JAL: begin
                    // Old PC (already PC+4) lands in $ra as the PC loads the target
                    PCWriteEn = 1'b1;
                    PCSource  = PCSRC_JUMP;
                    RegWrite  = 1'b1;
                    RegDst    = REGDST_RA;
                    MemtoReg  = M2R_PC;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : mips_mc_ctrl_fsm
`default_nettype wire
